// File: rtl/food_generator.sv
// Food placement for the snake game: draws LFSR grid coordinates, rejects out-of-grid
// or occupied cells, and hands the new food (or a give-up) back to the game FSM.
module food_generator #(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned X_W       = 6,
    parameter int unsigned Y_W       = 5,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_TRIES = 255,
    parameter int unsigned INIT_X    = 30,
    parameter int unsigned INIT_Y    = 15
) (
    input  logic           clk,
    input  logic           RST,
    input  logic           gen_req,
    input  logic           occupied,
    output logic [X_W-1:0] query_x,
    output logic [Y_W-1:0] query_y,
    output logic           gen_done,
    output logic           gen_fail,
    output logic [X_W-1:0] food_x,
    output logic [Y_W-1:0] food_y,
    output logic           busy
);

    localparam logic [7:0]     MaxTries = 8'(MAX_TRIES);
    localparam logic [X_W-1:0] InitX    = X_W'(INIT_X);
    localparam logic [Y_W-1:0] InitY    = Y_W'(INIT_Y);

    typedef enum logic [1:0] {StIdle, StDraw, StCheck, StDone} state_e;

    state_e         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [7:0]     tries_q, tries_d;
    logic [X_W-1:0] qx_q, qx_d;
    logic [Y_W-1:0] qy_q, qy_d;
    logic [X_W-1:0] food_x_q, food_x_d;
    logic [Y_W-1:0] food_y_q, food_y_d;
    logic           fail_q, fail_d;

    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] cand_y;
    logic           cand_out;
    logic           hit_food;
    logic [7:0]     tries_inc;
    logic           budget_hit;

    assign cand_x     = lfsr_q[X_W-1:0];
    assign cand_y     = lfsr_q[15:16-Y_W];
    assign cand_out   = (32'(cand_x) >= GRID_W) || (32'(cand_y) >= GRID_H);
    assign hit_food   = (qx_q == food_x_q) && (qy_q == food_y_q);
    assign tries_inc  = tries_q + 8'd1;
    assign budget_hit = (tries_inc == MaxTries);

    always_comb begin
        // Free-running: draws depend on when the request arrives.
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d  = state_q;
        tries_d  = tries_q;
        qx_d     = qx_q;
        qy_d     = qy_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        fail_d   = fail_q;

        unique case (state_q)
            StIdle: begin
                tries_d = 8'd0;
                fail_d  = 1'b0;
                if (gen_req) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (!gen_req) begin
                    state_d = StIdle;
                end else if (cand_out) begin
                    tries_d = tries_inc;
                    if (budget_hit) begin
                        state_d = StDone;
                        fail_d  = 1'b1;
                    end
                end else begin
                    qx_d    = cand_x;
                    qy_d    = cand_y;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!gen_req) begin
                    state_d = StIdle;
                end else if (occupied || hit_food) begin
                    tries_d = tries_inc;
                    if (budget_hit) begin
                        state_d = StDone;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = StDraw;
                    end
                end else begin
                    food_x_d = qx_q;
                    food_y_d = qy_q;
                    state_d  = StDone;
                    fail_d   = 1'b0;
                end
            end
            StDone: begin
                // Hold until the request drops so one GENFOOD phase yields one food.
                if (!gen_req) begin
                    state_d = StIdle;
                    fail_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            lfsr_q   <= SEED;
            tries_q  <= 8'd0;
            qx_q     <= '0;
            qy_q     <= '0;
            food_x_q <= InitX;
            food_y_q <= InitY;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tries_q  <= tries_d;
            qx_q     <= qx_d;
            qy_q     <= qy_d;
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
            fail_q   <= fail_d;
        end
    end

    assign query_x  = qx_q;
    assign query_y  = qy_q;
    assign food_x   = food_x_q;
    assign food_y   = food_y_q;
    assign gen_done = (state_q == StDone);
    assign gen_fail = fail_q;
    assign busy     = (state_q == StDraw) || (state_q == StCheck);

endmodule

// File: tb/tb_food_generator.sv
// Directed bench for food_generator: LFSR reference model plus a draw-sequence predictor
// that gives the expected food, tries and exact cycle of gen_done.
module tb_food_generator;

    localparam int GridW = 40;
    localparam int GridH = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       gen_req;
    logic       gen_req4;
    logic       occupied;
    logic [5:0] query_x, query_x4;
    logic [4:0] query_y, query_y4;
    logic       gen_done, gen_done4;
    logic       gen_fail, gen_fail4;
    logic [5:0] food_x, food_x4;
    logic [4:0] food_y, food_y4;
    logic       busy, busy4;

    always #5 clk = ~clk;

    food_generator dut (
        .clk      (clk),
        .RST      (rst),
        .gen_req  (gen_req),
        .occupied (occupied),
        .query_x  (query_x),
        .query_y  (query_y),
        .gen_done (gen_done),
        .gen_fail (gen_fail),
        .food_x   (food_x),
        .food_y   (food_y),
        .busy     (busy)
    );

    food_generator #(.MAX_TRIES(4)) dut4 (
        .clk      (clk),
        .RST      (rst),
        .gen_req  (gen_req4),
        .occupied (1'b1),
        .query_x  (query_x4),
        .query_y  (query_y4),
        .gen_done (gen_done4),
        .gen_fail (gen_fail4),
        .food_x   (food_x4),
        .food_y   (food_y4),
        .busy     (busy4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= lfsr_step(lfsr_m);
    end

    // Cells reported occupied to the main DUT.
    logic [5:0] occ_x[4];
    logic [4:0] occ_y[4];
    int         occ_n = 0;

    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < occ_n && query_x == occ_x[i] && query_y == occ_y[i]) occupied = 1'b1;
        end
    end

    logic [5:0] ex, cur_fx, prev_fx;
    logic [4:0] ey, cur_fy, prev_fy;
    int         e_cyc, e_tries, e_chk;
    bit         e_fail;

    // l0 is the LFSR value in the first DRAW cycle (cycle 0). The first n_occ in-range
    // candidates not equal to the food are marked occupied.
    task automatic predict(input logic [15:0] l0, input int n_occ, input bit occ_all,
                           input int max_tries, input logic [5:0] fx, input logic [4:0] fy);
        logic [15:0] l;
        logic [5:0]  cx;
        logic [4:0]  cy;
        int          t, cyc, used;
        bit          in_set, pick, is_food;
        l = l0; t = 0; cyc = 0; used = 0;
        occ_n = 0; e_fail = 0; e_chk = -1; ex = fx; ey = fy;
        for (int g = 0; g < 1000; g++) begin
            cx = l[5:0];
            cy = l[15:11];
            if (32'(cx) >= GridW || 32'(cy) >= GridH) begin
                t++; cyc++; l = lfsr_step(l);
                if (t == max_tries) begin e_fail = 1; break; end
            end else begin
                if (e_chk < 0) e_chk = cyc + 1;
                in_set = occ_all;
                for (int i = 0; i < occ_n; i++)
                    if (occ_x[i] == cx && occ_y[i] == cy) in_set = 1;
                is_food = (cx == fx) && (cy == fy);
                pick = !in_set && used < n_occ && !is_food;
                if (pick) begin
                    occ_x[occ_n] = cx; occ_y[occ_n] = cy; occ_n++; used++;
                end
                if (in_set || pick || is_food) begin
                    t++; cyc += 2; l = lfsr_step(lfsr_step(l));
                    if (t == max_tries) begin e_fail = 1; break; end
                end else begin
                    ex = cx; ey = cy; cyc += 2; break;
                end
            end
        end
        e_cyc = cyc;
        e_tries = t;
    endtask

    // Called at a negedge with the main DUT idle; returns at the first DONE negedge.
    task automatic run_gen(input int n_occ, input string tag);
        gen_req = 1'b1;
        @(negedge clk);
        predict(lfsr_m, n_occ, 1'b0, 255, cur_fx, cur_fy);
        check_eq({tag, " busy in draw"}, 32'(busy), 32'd1);
        repeat (e_cyc - 1) @(negedge clk);
        check_eq({tag, " done not early"}, 32'(gen_done), 32'd0);
        @(negedge clk);
        check_eq({tag, " gen_done"}, 32'(gen_done), 32'd1);
        check_eq({tag, " gen_fail"}, 32'(gen_fail), 32'd0);
        check_eq({tag, " food_x"}, 32'(food_x), 32'(ex));
        check_eq({tag, " food_y"}, 32'(food_y), 32'(ey));
        check_eq({tag, " busy off"}, 32'(busy), 32'd0);
        cur_fx = ex;
        cur_fy = ey;
    endtask

    initial begin
        rst = 1'b1; gen_req = 1'b0; gen_req4 = 1'b0;
        cur_fx = 6'd30; cur_fy = 5'd15;
        repeat (2) @(negedge clk);
        check_eq("rst food_x", 32'(food_x), 32'd30);
        check_eq("rst food_y", 32'(food_y), 32'd15);
        check_eq("rst query_x", 32'(query_x), 32'd0);
        check_eq("rst query_y", 32'(query_y), 32'd0);
        check_eq("rst gen_done", 32'(gen_done), 32'd0);
        check_eq("rst gen_fail", 32'(gen_fail), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("lfsr step1", 32'(dut.lfsr_q), 32'h000059C3);
        @(negedge clk);
        check_eq("lfsr step2", 32'(dut.lfsr_q), 32'h0000B387);

        // Reset during CHECK: everything back at once, no clock needed.
        gen_req = 1'b1;
        @(negedge clk);
        predict(lfsr_m, 0, 1'b0, 255, cur_fx, cur_fy);
        repeat (e_chk) @(negedge clk);
        check_eq("busy in check", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst food_x", 32'(food_x), 32'd30);
        check_eq("midrst food_y", 32'(food_y), 32'd15);
        check_eq("midrst query_x", 32'(query_x), 32'd0);
        check_eq("midrst query_y", 32'(query_y), 32'd0);
        check_eq("midrst gen_done", 32'(gen_done), 32'd0);
        check_eq("midrst busy", 32'(busy), 32'd0);
        gen_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Free board.
        run_gen(0, "free");
        check_eq("free x range", 32'(food_x < 6'd40), 32'd1);
        check_eq("free y range", 32'(food_y < 5'd30), 32'd1);
        check_eq("query x range", 32'(query_x < 6'd40), 32'd1);
        check_eq("query y range", 32'(query_y < 5'd30), 32'd1);
        gen_req = 1'b0;
        @(negedge clk);
        check_eq("free release done", 32'(gen_done), 32'd0);

        // First two in-range candidates occupied.
        repeat (2) @(negedge clk);
        run_gen(2, "occ2");
        check_eq("occ2 tries", 32'(dut.tries_q), 32'(e_tries));
        gen_req = 1'b0;
        @(negedge clk);
        occ_n = 0;

        // Request withdrawn during DRAW.
        gen_req = 1'b1;
        @(negedge clk);
        check_eq("abort busy", 32'(busy), 32'd1);
        gen_req = 1'b0;
        @(negedge clk);
        check_eq("abort idle", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("abort no done", 32'(gen_done), 32'd0);
            check_eq("abort food_x", 32'(food_x), 32'(cur_fx));
            @(negedge clk);
        end
        run_gen(0, "retry");

        // Request held high across DONE, then a one-cycle gap.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("hold done", 32'(gen_done), 32'd1);
            check_eq("hold food", 32'({food_x, food_y}), 32'({cur_fx, cur_fy}));
        end
        gen_req = 1'b0;
        @(negedge clk);
        check_eq("gap done low", 32'(gen_done), 32'd0);
        prev_fx = cur_fx;
        prev_fy = cur_fy;
        run_gen(0, "regen");
        check_eq("regen differs", 32'((food_x != prev_fx) || (food_y != prev_fy)), 32'd1);
        gen_req = 1'b0;
        @(negedge clk);

        // Budget of 4 with every cell occupied.
        gen_req4 = 1'b1;
        @(negedge clk);
        predict(lfsr_m, 0, 1'b1, 4, 6'd30, 5'd15);
        check_eq("fail busy", 32'(busy4), 32'd1);
        repeat (e_cyc - 1) @(negedge clk);
        check_eq("fail not early", 32'(gen_done4), 32'd0);
        @(negedge clk);
        check_eq("fail gen_done", 32'(gen_done4), 32'd1);
        check_eq("fail gen_fail", 32'(gen_fail4), 32'd1);
        check_eq("fail tries", 32'(dut4.tries_q), 32'd4);
        check_eq("fail food", 32'({food_x4, food_y4}), 32'({6'd30, 5'd15}));
        gen_req4 = 1'b0;
        @(negedge clk);
        check_eq("fail release done", 32'(gen_done4), 32'd0);
        check_eq("fail release fail", 32'(gen_fail4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/food_generator.md
Name: food_generator

Overview:
- Produces the next food cell for the snake game on request from the game state machine's GENFOOD phase, and returns the done level that releases it to RENDER.
- Draws pseudo-random grid coordinates from a free-running 16-bit LFSR, rejects out-of-range draws, and probes the snake-body occupancy map through a query port.
- Retries until a free cell is found or the retry budget is exhausted.
- Sits between the game state machine (generate_food / GEN_DONE) and the snake body store / renderer (food position).

Parameters:
- GRID_W, 40, grid width in cells (640/16).
- GRID_H, 30, grid height in cells (480/16).
- X_W, 6, x coordinate width.
- Y_W, 5, y coordinate width.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- MAX_TRIES, 255, rejected draws allowed before giving up; max 255.
- INIT_X, 30, food x after reset.
- INIT_Y, 15, food y after reset.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- RST, input, 1, asynchronous active-high reset.
- gen_req, input, 1, level request from the state machine; high for the whole GENFOOD phase.
- occupied, input, 1, occupancy answer for (query_x, query_y); combinational from the registered query; valid in the CHECK cycle.
- query_x, output, X_W, candidate x presented to the occupancy store.
- query_y, output, Y_W, candidate y presented to the occupancy store.
- gen_done, output, 1, level: new food ready (or gave up); feeds GEN_DONE.
- gen_fail, output, 1, level alongside gen_done: budget exhausted, food unchanged.
- food_x, output, X_W, current food x.
- food_y, output, Y_W, current food y.
- busy, output, 1, high in DRAW or CHECK.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, lfsr=SEED, tries=0.
  - food_x=INIT_X, food_y=INIT_Y.
  - query_x=0, query_y=0.
  - gen_done=0, gen_fail=0, busy=0.
  - Reset asserted mid-operation aborts immediately; no partial food update.
- LFSR:
  - Fibonacci, taps 16,14,13,11.
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances every clock in every state, so draws depend on request timing.
  - Never reaches zero.
- Candidate: cx = lfsr[X_W-1:0], cy = lfsr[15:16-Y_W], sampled in DRAW.
- IDLE: gen_done=0, gen_fail=0, tries cleared. gen_req=1 -> DRAW.
- DRAW (one cycle per draw):
  - If cx>=GRID_W or cy>=GRID_H: reject, tries+1, stay in DRAW.
  - Else: register query_x=cx, query_y=cy, -> CHECK.
- CHECK (one cycle):
  - occupied=1, or (query == current food): reject, tries+1, -> DRAW.
  - Else: food_x<=query_x, food_y<=query_y, -> DONE, gen_done=1 from the next cycle.
- Budget: the reject that makes tries==MAX_TRIES -> DONE with gen_fail=1; food unchanged.
- DONE: gen_done held at 1 (and gen_fail as set) while gen_req=1. gen_req=0 -> IDLE; gen_done drops the following cycle.
- gen_req dropped in DRAW/CHECK: -> IDLE next edge; food unchanged; gen_done never pulses.
- gen_req held high across DONE: stays in DONE; no second generation until gen_req has gone low for at least one cycle.
- Latency:
  - Best case: gen_req sampled high -> gen_done high at edge 3 (DRAW, CHECK, DONE).
  - Each rejected draw adds 1 cycle; each occupancy reject adds 2.
- food_x/food_y change only on a CHECK->DONE transition or reset.

Test Plan:
- Reset with SEED=16'hACE1: food=(30,15), gen_done=0, busy=0, query=(0,0). Assert RST during CHECK -> same values immediately, without waiting for a clock.
- occupied tied 0, gen_req raised at a known cycle after reset: food equals the first in-range LFSR draw from the reference model; gen_done high ≥3 cycles after gen_req; no output values ≥40 or ≥30.
- occupied=1 for the first two in-range queries, then 0: exactly two extra CHECK visits; final food equals the third in-range draw; tries=2 before DONE.
- occupied tied 1, MAX_TRIES=4: gen_done=1 and gen_fail=1 after the 4th reject; food stays (30,15). Drop gen_req -> gen_done=0, gen_fail=0 next cycle.
- gen_req dropped in the cycle after DRAW: returns to IDLE; food unchanged; gen_done stays 0. Reassert -> normal generation completes.
- gen_req held high 20 cycles after DONE: gen_done stays 1 and food is stable. Low 1 cycle, then high: a new food is produced, and it differs from the previous one.
